systolic_skew_feeder: RTL and testbench

- Upstream feeder for an N×N output-stationary systolic array built from systolicCell.
- Accepts one k-step per handshake: a column of A (N values, one per array row) and a row of B (N values, one per array column).
- Skews lane i by i cycles so every operand pair meets at the correct cell. Then pushes zeros until the last wavefront reaches cell (N-1,N-1).
- Emits the accumulator clear pulse at job start and the done pulse at job end.

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/skew_delay_line.sv | 30 +++
 rtl/systolic_skew_feeder.sv | 147 ++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feeder slice.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Cycles of zero injection needed for the last wavefront to reach cell (N-1,N-1).
   function automatic int flush_len(input int n);
      return 32'sd2 * n - 32'sd1;
   endfunction

   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register shift line; shifts every cycle regardless of upstream state.
module skew_delay_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_r [DEPTH];

   // Shift register chain, oldest value at the last stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            stage_r[k] <= {WIDTH{1'b0}};
         end
      end else begin
         stage_r[0] <= d;
         for (int k = 1; k < DEPTH; k++) begin
            stage_r[k] <= stage_r[k-1];
         end
      end
   end

   assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Feeds skewed A columns / B rows into an NxN output-stationary systolic array,
// bracketing each job with an accumulator clear and a completion pulse.
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int KW    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [KW-1:0]      k_len,
   output logic               busy,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] a_vec,
   input  logic [N*WIDTH-1:0] b_vec,
   output logic [N*WIDTH-1:0] a_edge,
   output logic [N*WIDTH-1:0] b_edge,
   output logic               acc_clr,
   output logic               done
);

   localparam int FLUSH_LEN = flush_len(N);
   localparam int FW        = $clog2(FLUSH_LEN + 32'sd1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 32'sd1);
   localparam logic [KW-1:0] STEP_ONE   = KW'(32'd1);

   state_t          state_r;
   state_t          state_s;
   logic [KW-1:0]   k_len_r;
   logic [KW-1:0]   step_cnt_r;
   logic [KW-1:0]   step_inc_s;
   logic [FW-1:0]   flush_cnt_r;
   logic            busy_r;
   logic            in_ready_r;
   logic            acc_clr_r;
   logic            done_r;
   logic            accept_s;

   // in_ready_r mirrors (state_r == FEED), so accepts never depend combinationally on in_valid.
   assign accept_s   = in_valid & in_ready_r;
   assign step_inc_s = step_cnt_r + STEP_ONE;

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (k_len != {KW{1'b0}}) begin
                  state_s = FEED;
               end else begin
                  state_s = DONE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         FEED: begin
            if (accept_s && (step_inc_s == k_len_r)) begin
               state_s = FLUSH;
            end else begin
               state_s = FEED;
            end
         end
         FLUSH: begin
            if (flush_cnt_r == FLUSH_LAST) begin
               state_s = DONE;
            end else begin
               state_s = FLUSH;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         busy_r     <= 1'b0;
         in_ready_r <= 1'b0;
         acc_clr_r  <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         busy_r     <= (state_s != IDLE);
         in_ready_r <= (state_s == FEED);
         acc_clr_r  <= (state_r == IDLE) && start;
         done_r     <= (state_r == DONE);
      end
   end

   // Job length latch, step counter and flush counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_len_r     <= {KW{1'b0}};
         step_cnt_r  <= {KW{1'b0}};
         flush_cnt_r <= {FW{1'b0}};
      end else begin
         if ((state_r == IDLE) && start) begin
            k_len_r    <= k_len;
            step_cnt_r <= {KW{1'b0}};
         end else if (accept_s) begin
            step_cnt_r <= step_inc_s;
         end
         if ((state_r == FLUSH) && (state_s == FLUSH)) begin
            flush_cnt_r <= flush_cnt_r + FW'(32'd1);
         end else begin
            flush_cnt_r <= {FW{1'b0}};
         end
      end
   end

   // Non-accept slots inject zeros so the skew stays aligned and bubbles add nothing.
   for (genvar i = 0; i < N; i++) begin : g_lane
      localparam int LSB = lane_lsb(i, WIDTH);
      logic [WIDTH-1:0] a_lane_s;
      logic [WIDTH-1:0] b_lane_s;

      assign a_lane_s = accept_s ? a_vec[LSB +: WIDTH] : {WIDTH{1'b0}};
      assign b_lane_s = accept_s ? b_vec[LSB +: WIDTH] : {WIDTH{1'b0}};

      skew_delay_line #(.WIDTH(WIDTH), .DEPTH(i + 32'sd1)) u_a_skew (
         .clk (clk),
         .rst (rst),
         .d   (a_lane_s),
         .q   (a_edge[LSB +: WIDTH])
      );

      skew_delay_line #(.WIDTH(WIDTH), .DEPTH(i + 32'sd1)) u_b_skew (
         .clk (clk),
         .rst (rst),
         .d   (b_lane_s),
         .q   (b_edge[LSB +: WIDTH])
      );
   end

   assign busy     = busy_r;
   assign in_ready = in_ready_r;
   assign acc_clr  = acc_clr_r;
   assign done     = done_r;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder with a behavioural 4x4 output-stationary array.
module tb_systolic_skew_feeder;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int KW = 8;

   logic            clk;
   logic            rst;
   logic            start;
   logic [KW-1:0]   k_len;
   logic            busy;
   logic            in_valid;
   logic            in_ready;
   logic [N*W-1:0]  a_vec;
   logic [N*W-1:0]  b_vec;
   logic [N*W-1:0]  a_edge;
   logic [N*W-1:0]  b_edge;
   logic            acc_clr;
   logic            done;

   systolic_skew_feeder #(.WIDTH(W), .N(N), .KW(KW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .k_len    (k_len),
      .busy     (busy),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_vec    (a_vec),
      .b_vec    (b_vec),
      .a_edge   (a_edge),
      .b_edge   (b_edge),
      .acc_clr  (acc_clr),
      .done     (done)
   );

   typedef struct {
      int         due;
      int         lane;
      logic [7:0] a;
      logic [7:0] b;
   } sb_t;

   sb_t sb_q[$];

   int checks;
   int errors;
   int cyc;
   int exp_clr_cyc;
   int exp_done_cyc;
   int busy_from;
   int busy_to;
   bit exp_ready;
   int last_done_cyc;
   int start_cyc;
   int last_lat;
   int am [N][256];
   int bm [256][N];
   int ah [64][N];
   int bh [64][N];
   int acc [N][N];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Per-cycle comparison of all outputs plus the array model update.
   task automatic observe();
      logic [N*W-1:0] ea;
      logic [N*W-1:0] eb;
      int slot;
      ea = '0;
      eb = '0;
      for (int k = sb_q.size() - 1; k >= 0; k--) begin
         if (sb_q[k].due == cyc) begin
            ea[sb_q[k].lane*W +: W] = sb_q[k].a;
            eb[sb_q[k].lane*W +: W] = sb_q[k].b;
            sb_q.delete(k);
         end
      end
      check_val("a_edge", a_edge, ea);
      check_val("b_edge", b_edge, eb);
      check_val("acc_clr", acc_clr, (cyc == exp_clr_cyc));
      check_val("done", done, (cyc == exp_done_cyc));
      check_val("in_ready", in_ready, exp_ready);
      check_val("busy", busy, (cyc >= busy_from) && (cyc <= busy_to));
      if (done) last_done_cyc = cyc;
      slot = cyc % 64;
      for (int i = 0; i < N; i++) begin
         ah[slot][i] = int'(a_edge[i*W +: W]);
         bh[slot][i] = int'(b_edge[i*W +: W]);
      end
      if (acc_clr) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) acc[i][j] = 0;
      end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            acc[i][j] += ah[(cyc - j + 64) % 64][i] * bh[(cyc - i + 64) % 64][j];
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      observe();
   endtask

   task automatic drive_step(input int s);
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
         a_vec[i*W +: W] = am[i][s][7:0];
         b_vec[i*W +: W] = bm[s][i][7:0];
         sb_q.push_back('{cyc + 1 + i, i, a_vec[i*W +: W], b_vec[i*W +: W]});
      end
   endtask

   task automatic run_job(input int k, input int gap_at, input int gap_len, input bit poke_busy);
      int sum;
      start_cyc   = cyc;
      start       = 1'b1;
      k_len       = 8'(k);
      exp_clr_cyc = cyc + 1;
      busy_from   = cyc + 1;
      busy_to     = cyc + 100000;
      exp_ready   = (k != 0);
      if (k == 0) begin
         exp_done_cyc = cyc + 2;
         busy_to      = cyc + 1;
      end
      step();
      start = 1'b0;
      if (poke_busy) begin
         start = 1'b1;
         k_len = 8'd5;
         step();
         start = 1'b0;
      end
      for (int s = 0; s < k; s++) begin
         if (s == gap_at) repeat (gap_len) step();
         drive_step(s);
         if (s == k - 1) begin
            exp_ready    = 1'b0;
            exp_done_cyc = cyc + 2 * N + 1;
            busy_to      = exp_done_cyc - 1;
         end
         step();
         in_valid = 1'b0;
         a_vec    = $urandom();
         b_vec    = $urandom();
      end
      repeat (2 * N + 4) step();
      check_val("done_cycle", last_done_cyc, exp_done_cyc);
      check_val("sb_empty", sb_q.size(), 0);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            sum = 0;
            for (int s = 0; s < k; s++) sum += am[i][s] * bm[s][j];
            check_val($sformatf("acc_%0d_%0d", i, j), acc[i][j], sum);
         end
      end
      last_lat = last_done_cyc - start_cyc;
   endtask

   task automatic fill_random(input int k);
      for (int s = 0; s < k; s++)
         for (int i = 0; i < N; i++) begin
            am[i][s] = $urandom_range(0, 255);
            bm[s][i] = $urandom_range(0, 255);
         end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat_nb;
      int prev_done;
      checks = 0; errors = 0; cyc = 0;
      exp_clr_cyc = -1; exp_done_cyc = -1;
      busy_from = 0; busy_to = -1; exp_ready = 1'b0;
      last_done_cyc = -1; last_lat = 0;
      rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
      a_vec = '0; b_vec = '0;
      for (int s = 0; s < 64; s++)
         for (int i = 0; i < N; i++) begin ah[s][i] = 0; bh[s][i] = 0; end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) acc[i][j] = 0;

      repeat (3) step();
      rst = 1'b0;
      repeat (2) step();

      // in_valid while idle must not inject data
      in_valid = 1'b1; a_vec = 32'hdeadbeef; b_vec = 32'h12345678;
      repeat (3) step();
      in_valid = 1'b0;

      // single k-step with the documented operand pattern
      am[0][0] = 1; am[1][0] = 2; am[2][0] = 3; am[3][0] = 4;
      bm[0][0] = 5; bm[0][1] = 6; bm[0][2] = 7; bm[0][3] = 8;
      run_job(1, -1, 0, 1'b0);

      // identity A times B(i,j) = i*4+j
      for (int i = 0; i < N; i++)
         for (int s = 0; s < N; s++) begin
            am[i][s] = (i == s) ? 1 : 0;
            bm[s][i] = s * N + i;
         end
      run_job(4, -1, 0, 1'b0);

      // k_len=3 without and with a two-cycle bubble
      fill_random(3);
      run_job(3, -1, 0, 1'b0);
      lat_nb = last_lat;
      run_job(3, 1, 2, 1'b0);
      check_val("bubble_delay", last_lat - lat_nb, 2);

      // empty job with a start poked while busy
      run_job(0, -1, 0, 1'b1);

      // maximum job length
      fill_random(255);
      run_job(255, -1, 0, 1'b0);

      // reset while flushing
      fill_random(1);
      start = 1'b1; k_len = 8'd1;
      exp_clr_cyc = cyc + 1; busy_from = cyc + 1; busy_to = cyc + 100000; exp_ready = 1'b1;
      step();
      start = 1'b0;
      drive_step(0);
      exp_ready = 1'b0; exp_done_cyc = cyc + 2 * N + 1; busy_to = exp_done_cyc - 1;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      prev_done = last_done_cyc;
      #2 rst = 1'b1;
      #1;
      check_val("rst_a_edge", a_edge, 32'h0);
      check_val("rst_b_edge", b_edge, 32'h0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_in_ready", in_ready, 1'b0);
      check_val("rst_acc_clr", acc_clr, 1'b0);
      check_val("rst_done", done, 1'b0);
      sb_q.delete();
      exp_done_cyc = -1; exp_clr_cyc = -1; exp_ready = 1'b0;
      busy_from = 0; busy_to = -1;
      step();
      rst = 1'b0;
      repeat (14) step();
      check_val("rst_no_done", last_done_cyc, prev_done);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
